// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide, byte-addressed data memory.
// Aligns and extends load data, does read-modify-write for byte/halfword
// stores, and rejects misaligned or illegal-size requests without any
// memory access. All memory-side outputs come straight from flops.
module mem_access_unit #(
  parameter int depth = 1024,
  parameter int width = 8,
  localparam int AW   = $clog2(depth),
  localparam int W    = 4 * width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  output logic          rsp_valid,
  output logic [W-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] Read_address,
  output logic [AW-1:0] write_address,
  output logic [W-1:0]  WD,
  output logic          WE,
  input  logic [W-1:0]  RD
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          wr_en_q, wr_en_d;
  logic [W-1:0]  wd_q, wd_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;

  logic          accept;
  logic          bad_req;
  logic [1:0]    lane_q;
  logic [AW-1:0] req_word;
  logic [AW-1:0] held_word;
  logic [W-1:0]  rd_shift;
  logic [W-1:0]  wd_shift;
  logic [W-1:0]  load_data;
  logic [3:0]    be;
  logic [3:0][width-1:0] rd_lanes, wd_lanes, mrg_lanes;

  assign accept    = req_valid & ready_q;
  assign bad_req   = (req_size == 2'b11)
                   | ((req_size == SZ_H) & req_addr[0])
                   | ((req_size == SZ_W) & (|req_addr[1:0]));
  assign lane_q    = addr_q[1:0];
  assign req_word  = {req_addr[AW-1:2], 2'b00};
  assign held_word = {addr_q[AW-1:2], 2'b00};

  // Load path: bring the addressed lane(s) down to bit 0, then extend.
  assign rd_shift = RD >> (width * lane_q);

  // Load extension; word loads ignore the signed flag.
  always_comb begin
    load_data = rd_shift;
    case (size_q)
      SZ_B: load_data = {{(W-width){sgn_q & rd_shift[width-1]}}, rd_shift[width-1:0]};
      SZ_H: load_data = {{(W-2*width){sgn_q & rd_shift[2*width-1]}}, rd_shift[2*width-1:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Store path: move right-justified store data up to its lane(s) and
  // overlay only the enabled lanes onto the word read from memory.
  assign wd_shift = wdata_q << (width * lane_q);
  assign rd_lanes = RD;
  assign wd_lanes = wd_shift;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    // Lane enable: exact lane for bytes, matching half for halfwords.
    always_comb begin
      case (size_q)
        SZ_B:    be[l] = (lane_q == 2'(l));
        SZ_H:    be[l] = (lane_q[1] == 1'(l / 2));
        default: be[l] = 1'b1;
      endcase
    end
    assign mrg_lanes[l] = be[l] ? wd_lanes[l] : rd_lanes[l];
  end

  // Next-state and registered-output logic, one state per cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wd_d        = wd_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wr_en_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          we_d      = req_we;
          size_d    = req_size;
          sgn_d     = req_signed;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          rd_addr_d = req_word;
          ready_d   = 1'b0;
          if (bad_req) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_size == SZ_W) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wd_d      = req_wdata;
            wr_addr_d = req_word;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wd_d      = mrg_lanes;
          wr_addr_d = held_word;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP, ERR: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output flops; reset kills any in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wd_q        <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_en_q     <= wr_en_d;
      wd_q        <= wd_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign WE            = wr_en_q;
  assign WD            = wd_q;
  assign Read_address  = rd_addr_q;
  assign write_address = wr_addr_q;

endmodule
